imem_program_encoder: RTL
=========================

# imem_program_encoder

Sequential instruction encoder and loader for the pipelined MIPS core. It accepts a stream of symbolic instruction commands over a valid/ready handshake and packs each one into a 32-bit MIPS word. Supported classes are R-type, lw, sw, addi, andi, ori, slti, beq, bne and j. Each word is written to consecutive instruction-memory locations while the core is held stalled; on completion it releases the core to fetch from BASE_ADDR.

## Interface
Parameters:
- DEPTH, 256: instruction-memory capacity in 32-bit words (power of 2, ≥ 2).
- BASE_ADDR, 32'h0000_0000: byte address of the first written word (word-aligned).

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a load session; sampled in IDLE or DONE only.
- cmd_valid  in  1  command beat valid.
- cmd_ready  out  1  encoder can accept a beat.
- cmd_kind  in  4  0 R, 1 lw, 2 sw, 3 addi, 4 andi, 5 ori, 6 slti, 7 beq, 8 bne, 9 j; 10–15 illegal.
- cmd_fsel  in  3  R-type function: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 nor, 6 sll, 7 srl.
- cmd_rs, cmd_rt, cmd_rd, cmd_shamt  in  5 each  register and shift fields.
- cmd_imm  in  16  immediate field.
- cmd_target  in  26  jump word index; branch absolute word index when ENC_BRANCH_REL_EN is defined.
- cmd_last  in  1  final beat of the program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  32  byte write address.
- imem_wdata  out  32  encoded instruction.
- cpu_hold  out  1  stall/hold for the core.
- done  out  1  load complete.
- err  out  1  sticky error flag.
- count  out  $clog2(DEPTH)+1  number of words written in this session.

## Operation
- FSM states:
  - IDLE: leaves on start and goes to LOAD.
  - LOAD: leaves on an accepted beat with cmd_last, or on an accepted beat that makes count reach DEPTH; goes to DONE.
  - DONE: leaves on start and goes to LOAD.
- Entering LOAD clears count and err, and sets the write pointer to BASE_ADDR.
- start asserted while in LOAD is ignored.
- cmd_ready = (state == LOAD). A beat is accepted when cmd_valid && cmd_ready.
- Opcodes (6 bits): R 000000, lw 100011, sw 101011, addi 001000, andi 001100, ori 001101, slti 001010, beq 000100, bne 000101, j 000010.
- R-type function codes: add 100000, sub 100010, and 100100, or 100101, slt 101010, nor 100111, sll 000000, srl 000010.
- Word formats:
  - R: {op, rs, rt, rd, shamt, funct}.
  - I: {op, rs, rt, imm16}.
  - J: {op, target26}.
  - For sll/srl, shamt comes from cmd_shamt and rs is forced to 0.
  - For non-shift R-type, shamt is forced to 0.
- Illegal cmd_kind: the encoder writes 32'h0000_0000 (NOP), sets err, and the address still advances.
- Pointer and count:
  - The write pointer advances by 4 per accepted beat.
  - count increments by 1 per accepted beat.
- If count reaches DEPTH on a beat without cmd_last, the session ends in DONE and err is set.
- err stays set until the next session start or rst.
- done = (state == DONE).
- cpu_hold = (state == LOAD) || imem_we.
- Reset: state IDLE. All outputs 0: cmd_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err, count.
- rst during LOAD aborts the session immediately. No write is issued in the reset cycle.

## Timing
- Latency:
  - Beat accepted at edge N → imem_we=1 with that beat's imem_addr and imem_wdata during cycle N+1.
  - imem_we is a single-cycle pulse per beat.
- Throughput is one word per cycle. Gaps in cmd_valid produce matching gaps in imem_we.
- count is updated at edge N, the same edge that accepts the beat.
- Last beat:
  - Accepted at edge N → state DONE and cmd_ready=0 from cycle N+1.
  - The final write occurs in cycle N+1; cpu_hold stays high through N+1 and drops in N+2.
- start in DONE → LOAD with cmd_ready=1 in the next cycle.

## Configuration
- ENC_BRANCH_REL_EN defined: for beq/bne, imm16 = cmd_target[15:0] − (cur_index + 1), modulo 2^16.
  - cur_index is the word offset of the current write from BASE_ADDR. cmd_imm is ignored.
- Not defined: beq/bne use cmd_imm verbatim as the branch offset.
- j always uses cmd_target as the 26-bit target field, regardless of the macro.

## Test plan
- R add, rs=1 rt=2 rd=3 at first beat → cycle after accept: imem_we=1, imem_addr=BASE_ADDR, imem_wdata=32'h00221820.
- lw rt=8 rs=29 imm=4, then sll rd=2 rt=1 shamt=4 with cmd_last → writes 32'h8FA80004 at +0 and 32'h00011100 at +4; done=1 and count=2; cpu_hold=0 two cycles after the last accept.
- With ENC_BRANCH_REL_EN: beq rs=1 rt=2 target=0 as the third word (index 2) → imem_wdata=32'h1022FFFD. Without the macro and with cmd_imm=16'h0005 → 32'h10220005.
- cmd_kind=15 mid-stream → imem_wdata=0 and err=1; following beats still encode correctly; err clears on the next start.
- DEPTH=4, four beats without cmd_last → done=1, err=1, count=4, cmd_ready=0. A fifth cmd_valid gets no write.
- Alternating cmd_valid 1/0 → imem_we alternates with one-cycle lag. rst asserted mid-load → all outputs 0 in the next cycle and state IDLE.

Source files
------------

// File: rtl/imem_program_encoder.sv
// imem_program_encoder: packs a valid/ready stream of symbolic MIPS commands
// into 32-bit instruction words and writes them to consecutive instruction-memory
// locations starting at BASE_ADDR, holding the core stalled while loading.
// Optional feature macro: ENC_BRANCH_REL_EN (beq/bne offset computed from an
// absolute target word index instead of taken verbatim from cmd_imm).
module imem_program_encoder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_kind,
    input  logic [2:0]               cmd_fsel,
    input  logic [4:0]               cmd_rs,
    input  logic [4:0]               cmd_rt,
    input  logic [4:0]               cmd_rd,
    input  logic [4:0]               cmd_shamt,
    input  logic [15:0]              cmd_imm,
    input  logic [25:0]              cmd_target,
    input  logic                     cmd_last,
    output logic                     imem_we,
    output logic [31:0]              imem_addr,
    output logic [31:0]              imem_wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] wr_ptr;

    logic [5:0]  funct_c;
    logic        shift_op_c;
    logic        illegal_c;
    logic [15:0] br_imm_c;
    logic [31:0] word_c;
    logic        at_cap_c;

    // Encode the presented command into a 32-bit MIPS instruction word.
    always_comb begin
        funct_c    = 6'b100000;
        shift_op_c = 1'b0;
        illegal_c  = 1'b0;
        word_c     = 32'h0000_0000;
        br_imm_c   = cmd_imm;
`ifdef ENC_BRANCH_REL_EN
        // Offset is relative to the instruction after the one being written.
        br_imm_c   = cmd_target[15:0] - (16'(count) + 16'd1);
`endif
        case (cmd_fsel)
            3'd0: funct_c = 6'b100000;
            3'd1: funct_c = 6'b100010;
            3'd2: funct_c = 6'b100100;
            3'd3: funct_c = 6'b100101;
            3'd4: funct_c = 6'b101010;
            3'd5: funct_c = 6'b100111;
            3'd6: begin funct_c = 6'b000000; shift_op_c = 1'b1; end
            3'd7: begin funct_c = 6'b000010; shift_op_c = 1'b1; end
            default: funct_c = 6'b100000;
        endcase
        case (cmd_kind)
            4'd0: word_c = {6'b000000, (shift_op_c ? 5'd0 : cmd_rs), cmd_rt, cmd_rd,
                            (shift_op_c ? cmd_shamt : 5'd0), funct_c};
            4'd1: word_c = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
            4'd2: word_c = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
            4'd3: word_c = {6'b001000, cmd_rs, cmd_rt, cmd_imm};
            4'd4: word_c = {6'b001100, cmd_rs, cmd_rt, cmd_imm};
            4'd5: word_c = {6'b001101, cmd_rs, cmd_rt, cmd_imm};
            4'd6: word_c = {6'b001010, cmd_rs, cmd_rt, cmd_imm};
            4'd7: word_c = {6'b000100, cmd_rs, cmd_rt, br_imm_c};
            4'd8: word_c = {6'b000101, cmd_rs, cmd_rt, br_imm_c};
            4'd9: word_c = {6'b000010, cmd_target};
            default: begin
                word_c    = 32'h0000_0000;
                illegal_c = 1'b1;
            end
        endcase
    end

    // The beat being accepted fills the last free memory word.
    assign at_cap_c = ((count + CW'(1)) == CW'(DEPTH));

    // Session FSM with registered handshake, write port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'h0000_0000;
            imem_wdata <= 32'h0000_0000;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
            wr_ptr     <= 32'h0000_0000;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        cmd_ready <= 1'b1;
                        cpu_hold  <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        count     <= '0;
                        wr_ptr    <= BASE_ADDR;
                    end else begin
                        cpu_hold  <= 1'b0;
                    end
                end
                LOAD: begin
                    cpu_hold <= 1'b1;
                    if (cmd_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= wr_ptr;
                        imem_wdata <= word_c;
                        wr_ptr     <= wr_ptr + 32'd4;
                        count      <= count + CW'(1);
                        if (illegal_c || (at_cap_c && !cmd_last)) begin
                            err <= 1'b1;
                        end
                        if (cmd_last || at_cap_c) begin
                            state     <= DONE;
                            cmd_ready <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    done      <= 1'b0;
                    cpu_hold  <= 1'b0;
                end
            endcase
        end
    end

endmodule
